// File: rtl/timer_sequencer_if.sv
// Bundle of the step-table write port, sequence control and timer-side signals
// of timer_sequencer. The slave modport is the sequencer; master is its driver.
interface timer_sequencer_if;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  num_steps;
  logic [7:0]  repeat_num;
  logic        seq_start;
  logic        seq_abort;
  logic        timeup;
  logic        timer_start;
  logic [15:0] timer_para;
  logic [2:0]  step_idx;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  // Handshake: seq_start is a single-cycle request honoured only while busy=0;
  // timer_start is a single-cycle command answered later by a rising timeup.
  modport slave (
    input  wr_en, wr_addr, wr_data, num_steps, repeat_num,
    input  seq_start, seq_abort, timeup,
    output timer_start, timer_para, step_idx, busy, done, state_dbg
  );

  modport master (
    output wr_en, wr_addr, wr_data, num_steps, repeat_num,
    output seq_start, seq_abort, timeup,
    input  timer_start, timer_para, step_idx, busy, done, state_dbg
  );
endinterface

// File: rtl/timer_sequencer.sv
// Steps a downstream timer through a table of intervals, optionally repeating
// the whole pass, and advances on each rising edge of the timer's expiry level.
module timer_sequencer #(
  parameter int NSTEP = 8
) (
  input logic             clk,
  input logic             rst_n,
  timer_sequencer_if.slave sif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FIRE = 3'd2,
    S_WAIT = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [3:0] MAX_STEPS = 4'(NSTEP);

  state_t      state;
  logic [15:0] table_q [0:NSTEP-1];
  logic [2:0]  step_idx_q;
  logic [7:0]  pass_cnt;
  logic [15:0] timer_para_q;
  logic        timer_start_q;
  logic        busy_q;
  logic        done_q;
  logic        timeup_d;

  logic        rise;
  logic        last_step;
  logic        last_pass;
  logic        start_ok;
  logic [7:0]  final_pass;

  always_comb begin
    final_pass = (sif.repeat_num == 8'd0) ? 8'd0 : sif.repeat_num - 8'd1;
    rise       = sif.timeup && !timeup_d;
    last_step  = ({1'b0, step_idx_q} == (sif.num_steps - 4'd1));
    last_pass  = (pass_cnt == final_pass);
    start_ok   = sif.seq_start && (sif.num_steps != 4'd0) && (sif.num_steps <= MAX_STEPS);
  end

  // Table is writable only while no sequence is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTEP; i++) table_q[i] <= '0;
    end else if (sif.wr_en && !busy_q) begin
      table_q[sif.wr_addr] <= sif.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      step_idx_q    <= '0;
      pass_cnt      <= '0;
      timer_para_q  <= '0;
      timer_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeup_d      <= 1'b1;
    end else begin
      timeup_d      <= sif.timeup;
      timer_start_q <= 1'b0;
      done_q        <= 1'b0;
      if (sif.seq_abort) begin
        // Abort leaves step_idx and timer_para where they were.
        state  <= S_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_ok) begin
              state      <= S_LOAD;
              step_idx_q <= '0;
              pass_cnt   <= '0;
              busy_q     <= 1'b1;
            end
          end
          S_LOAD: begin
            timer_para_q  <= table_q[step_idx_q];
            timer_start_q <= 1'b1;
            state         <= S_FIRE;
          end
          S_FIRE: state <= S_WAIT;
          S_WAIT: begin
            if (rise) state <= S_NEXT;
          end
          S_NEXT: begin
            if (!last_step) begin
              step_idx_q <= step_idx_q + 3'd1;
              state      <= S_LOAD;
            end else if (!last_pass) begin
              step_idx_q <= '0;
              pass_cnt   <= pass_cnt + 8'd1;
              state      <= S_LOAD;
            end else begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sif.timer_start = timer_start_q;
  assign sif.timer_para  = timer_para_q;
  assign sif.step_idx    = step_idx_q;
  assign sif.busy        = busy_q;
  assign sif.done        = done_q;
  assign sif.state_dbg   = state;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: sequencing, repeats, latency, abort,
// write lock, spurious timeup handling and reset.
module tb_timer_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  timer_sequencer_if sif ();

  timer_sequencer #(.NSTEP(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] exp_q [$];
  logic [15:0] got_para [$];
  logic [2:0]  got_idx [$];
  bit          saw_done;

  task automatic write_entry(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    sif.wr_en = 1'b1; sif.wr_addr = addr; sif.wr_data = data;
    @(negedge clk);
    sif.wr_en = 1'b0;
  endtask

  // Returns at the negedge just after the edge that sampled seq_start.
  task automatic start_seq(input logic [3:0] ns, input logic [7:0] rp);
    @(negedge clk);
    sif.num_steps = ns; sif.repeat_num = rp; sif.seq_start = 1'b1;
    @(negedge clk);
    sif.seq_start = 1'b0;
  endtask

  task automatic abort_seq();
    @(negedge clk);
    sif.seq_abort = 1'b1;
    @(negedge clk);
    sif.seq_abort = 1'b0;
  endtask

  // Answers every timer_start with a one-cycle timeup pulse 5 cycles later.
  task automatic run_seq(input int budget);
    int ack;
    ack = 0;
    got_para.delete(); got_idx.delete(); saw_done = 0;
    for (int n = 0; n < budget && !saw_done; n++) begin
      @(negedge clk);
      sif.timeup = 1'b0;
      if (ack > 0) begin
        ack--;
        if (ack == 0) sif.timeup = 1'b1;
      end
      if (sif.timer_start === 1'b1) begin
        got_para.push_back(sif.timer_para);
        got_idx.push_back(sif.step_idx);
        ack = 5;
      end
      if (sif.done === 1'b1) saw_done = 1;
    end
    sif.timeup = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({sif.timer_start, sif.timer_para, sif.step_idx, sif.busy, sif.done} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {sif.timer_start, sif.timer_para, sif.step_idx, sif.busy, sif.done});
    end
    total++;
    if (sif.state_dbg !== 3'd0) begin
      bad++; $display("FAIL reset_state got=%0d want=0", sif.state_dbg);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    write_entry(3'd0, 16'd100);
    write_entry(3'd1, 16'd200);
    write_entry(3'd2, 16'd300);
    exp_q = '{16'd100, 16'd200, 16'd300};
    start_seq(4'd3, 8'd1);
    run_seq(200);
    total++;
    if (!saw_done) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
    total++;
    if (got_para.size() != 3) begin
      bad++; $display("FAIL basic_count got=%0d want=3", got_para.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_para[i] !== exp_q[i]) begin
          bad++; $display("FAIL basic_para[%0d] got=%0d want=%0d", i, got_para[i], exp_q[i]);
        end
      end
    end
    @(negedge clk);
    total++;
    if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      bad++; $display("FAIL basic_end busy=%b done=%b want busy=0 done=0", sif.busy, sif.done);
    end
  endtask

  task automatic test_repeat(input logic [7:0] rp, input int npulse);
    start_seq(4'd2, rp);
    run_seq(300);
    total++;
    if (!saw_done) begin bad++; $display("FAIL repeat%0d_timeout got=no_done want=done", rp); end
    total++;
    if (got_idx.size() != npulse) begin
      bad++; $display("FAIL repeat%0d_count got=%0d want=%0d", rp, got_idx.size(), npulse);
    end else begin
      for (int i = 0; i < npulse; i++) begin
        total++;
        if (got_idx[i] !== 3'(i % 2)) begin
          bad++; $display("FAIL repeat%0d_idx[%0d] got=%0d want=%0d", rp, i, got_idx[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_latency();
    int e;
    int starts [$];
    @(negedge clk);
    sif.num_steps = 4'd2; sif.repeat_num = 8'd1; sif.seq_start = 1'b1;
    @(posedge clk);
    e = 10;
    #1 sif.seq_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sif.timer_start === 1'b1) starts.push_back(e + 1);
      sif.timeup = (e + 1 == 20);
      @(posedge clk);
      e++;
    end
    @(negedge clk);
    sif.timeup = 1'b0;
    total++;
    if (starts.size() != 2) begin
      bad++; $display("FAIL latency_count got=%0d want=2", starts.size());
    end else begin
      total++;
      if (starts[0] != 12) begin bad++; $display("FAIL latency_start got=%0d want=12", starts[0]); end
      total++;
      if (starts[1] != 23) begin bad++; $display("FAIL latency_next got=%0d want=23", starts[1]); end
    end
    abort_seq();
  endtask

  task automatic test_abort();
    int found;
    int cnt_start;
    int cnt_done;
    start_seq(4'd3, 8'd1);
    found = 0;
    for (int n = 0; n < 10 && found == 0; n++) begin
      @(negedge clk);
      if (sif.timer_start === 1'b1) found = 1;
    end
    @(negedge clk); @(negedge clk);
    sif.timeup = 1'b1;
    @(negedge clk);
    sif.timeup = 1'b0;
    found = 0;
    for (int n = 0; n < 10 && found == 0; n++) begin
      @(negedge clk);
      if (sif.timer_start === 1'b1) found = 1;
    end
    total++;
    if (found == 0) begin bad++; $display("FAIL abort_step1 got=no_start want=start"); end
    @(negedge clk);
    total++;
    if (sif.state_dbg !== 3'd3) begin bad++; $display("FAIL abort_pre got=%0d want=3", sif.state_dbg); end
    sif.seq_abort = 1'b1;
    @(negedge clk);
    sif.seq_abort = 1'b0;
    total++;
    if (sif.state_dbg !== 3'd0 || sif.busy !== 1'b0) begin
      bad++; $display("FAIL abort_idle state=%0d busy=%b want 0/0", sif.state_dbg, sif.busy);
    end
    total++;
    if (sif.timer_para !== 16'd200 || sif.step_idx !== 3'd1) begin
      bad++; $display("FAIL abort_hold para=%0d idx=%0d want 200/1", sif.timer_para, sif.step_idx);
    end
    cnt_start = 0; cnt_done = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      sif.timeup = (n == 3);
      if (sif.timer_start === 1'b1) cnt_start++;
      if (sif.done === 1'b1) cnt_done++;
    end
    sif.timeup = 1'b0;
    total++;
    if (cnt_start != 0 || cnt_done != 0) begin
      bad++; $display("FAIL abort_quiet starts=%0d dones=%0d want 0/0", cnt_start, cnt_done);
    end
  endtask

  task automatic test_write_lock();
    start_seq(4'd3, 8'd1);
    write_entry(3'd0, 16'hdead);
    abort_seq();
    start_seq(4'd1, 8'd1);
    run_seq(100);
    total++;
    if (got_para.size() != 1 || got_para[0] !== 16'd100) begin
      bad++; $display("FAIL write_lock got=%0d pulses para=%0d want=1 pulse para=100",
                      got_para.size(), (got_para.size() > 0) ? got_para[0] : 16'd0);
    end
  endtask

  task automatic test_spurious();
    int found;
    int cnt_start;
    start_seq(4'd3, 8'd1);
    found = 0;
    for (int n = 0; n < 10 && found == 0; n++) begin
      @(negedge clk);
      if (sif.timer_start === 1'b1) found = 1;
    end
    sif.timeup = 1'b1;
    cnt_start = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (sif.timer_start === 1'b1) cnt_start++;
    end
    total++;
    if (cnt_start != 0 || sif.step_idx !== 3'd0 || sif.state_dbg !== 3'd3) begin
      bad++; $display("FAIL spurious_hold starts=%0d idx=%0d state=%0d want 0/0/3",
                      cnt_start, sif.step_idx, sif.state_dbg);
    end
    sif.timeup = 1'b0;
    @(negedge clk);
    sif.timeup = 1'b1;
    found = 0;
    for (int n = 1; n <= 6 && found == 0; n++) begin
      @(negedge clk);
      sif.timeup = 1'b0;
      if (sif.timer_start === 1'b1) found = n;
    end
    total++;
    if (found != 3 || sif.step_idx !== 3'd1 || sif.timer_para !== 16'd200) begin
      bad++; $display("FAIL spurious_advance at=%0d idx=%0d para=%0d want 3/1/200",
                      found, sif.step_idx, sif.timer_para);
    end
    abort_seq();
  endtask

  task automatic test_idle_inputs();
    int cnt_start;
    int busy_seen;
    cnt_start = 0; busy_seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      sif.timeup = (n == 1);
      if (sif.timer_start === 1'b1) cnt_start++;
      if (sif.busy !== 1'b0) busy_seen++;
    end
    total++;
    if (cnt_start != 0 || busy_seen != 0) begin
      bad++; $display("FAIL idle_timeup starts=%0d busy=%0d want 0/0", cnt_start, busy_seen);
    end
    start_seq(4'd0, 8'd1);
    @(negedge clk);
    total++;
    if (sif.busy !== 1'b0) begin bad++; $display("FAIL bad_start_0 busy=%b want=0", sif.busy); end
    start_seq(4'd9, 8'd1);
    @(negedge clk);
    total++;
    if (sif.busy !== 1'b0) begin bad++; $display("FAIL bad_start_9 busy=%b want=0", sif.busy); end
    @(negedge clk);
    sif.num_steps = 4'd2; sif.seq_start = 1'b1; sif.seq_abort = 1'b1;
    @(negedge clk);
    sif.seq_start = 1'b0; sif.seq_abort = 1'b0;
    @(negedge clk);
    total++;
    if (sif.busy !== 1'b0 || sif.state_dbg !== 3'd0) begin
      bad++; $display("FAIL abort_wins busy=%b state=%0d want 0/0", sif.busy, sif.state_dbg);
    end
  endtask

  task automatic test_reset_mid();
    int cnt_start;
    start_seq(4'd2, 8'd1);
    total++;
    if (sif.state_dbg !== 3'd1) begin bad++; $display("FAIL rst_mid_load got=%0d want=1", sif.state_dbg); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({sif.timer_start, sif.timer_para, sif.step_idx, sif.busy, sif.done} !== 22'd0) begin
      bad++; $display("FAIL rst_mid_outputs got=%h want=0",
                      {sif.timer_start, sif.timer_para, sif.step_idx, sif.busy, sif.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt_start = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      sif.timeup = (n == 4);
      if (sif.timer_start === 1'b1) cnt_start++;
    end
    sif.timeup = 1'b0;
    total++;
    if (cnt_start != 0 || sif.busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_quiet starts=%0d busy=%b want 0/0", cnt_start, sif.busy);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    sif.wr_en = 1'b0; sif.wr_addr = '0; sif.wr_data = '0;
    sif.num_steps = '0; sif.repeat_num = '0;
    sif.seq_start = 1'b0; sif.seq_abort = 1'b0; sif.timeup = 1'b0;
    test_reset();
    test_basic();
    test_repeat(8'd3, 6);
    test_repeat(8'd0, 2);
    test_latency();
    test_abort();
    test_write_lock();
    test_spurious();
    test_idle_inputs();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
